// File: rtl/gate_vec_checker_pkg.sv
// ---------------------------------------------------------------------------
// gate_chk_pkg: shared types and helpers for the gate vector checker.
//   state_t  - checker FSM state encoding (3-bit)
//   ERR_SAT  - saturation limit of the mismatch counter
//   exp3()   - expected {AND, OR, XOR} response of the 2-input gate block
// ---------------------------------------------------------------------------
package gate_chk_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned ERR_W   = 3;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned WAIT_W  = 4;
    localparam int unsigned RESP_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ERR_W-1:0] ERR_SAT = 3'd7;

    // Golden gate response, ordered {y1, y2, y3}.
    function automatic logic [RESP_W-1:0] exp3(input logic a, input logic b);
        return {a & b, a | b, a ^ b};
    endfunction

endpackage

// File: rtl/gate_vec_checker_if.sv
// ---------------------------------------------------------------------------
// gate_vec_checker_if: stimulus/response bus between the checker and the
// 2-input gate block under test.
//   a, b       - stimulus into the gate
//   y1, y2, y3 - gate AND / OR / XOR responses
//   master     - checker side (drives a/b, samples y1..y3)
//   slave      - gate side (consumes a/b, drives y1..y3)
// ---------------------------------------------------------------------------
interface gate_vec_checker_if;

    logic a;
    logic b;
    logic y1;
    logic y2;
    logic y3;

    modport master (
        output a,
        output b,
        input  y1,
        input  y2,
        input  y3
    );

    modport slave (
        input  a,
        input  b,
        output y1,
        output y2,
        output y3
    );

endinterface

// File: rtl/gate_vec_checker_ref_model.sv
// ---------------------------------------------------------------------------
// gate_ref_model: combinational golden model of the 2-input gate block.
//   a, b     - gate inputs
//   y_exp_c  - expected {AND, OR, XOR} response (combinational)
// ---------------------------------------------------------------------------
module gate_ref_model
    import gate_chk_pkg::*;
(
    input  logic              a,
    input  logic              b,
    output logic [RESP_W-1:0] y_exp_c
);

    assign y_exp_c = exp3(a, b);

endmodule

// File: rtl/gate_vec_checker.sv
// ---------------------------------------------------------------------------
// gate_vec_checker: clocked stimulus/response checker for the 2-input gate.
// Walks {a,b} = 0..NVEC-1, waits SETTLE clocks after each change, compares
// the gate's y1..y3 with the reference and reports the outcome.
//   clk, reset  - clock and synchronous active-high reset
//   start       - one-cycle pulse; launches a run from IDLE or DONE
//   gate        - master side of the gate bus (a/b out, y1..y3 in)
//   busy        - run in progress
//   done        - run finished; held until next start or reset
//   pass        - valid with done: no mismatching vectors
//   err_count   - mismatching vectors this run, saturating at 7
//   first_fail  - index of the first mismatching vector, 0 if none
// ---------------------------------------------------------------------------
module gate_vec_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned NVEC   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    gate_vec_checker_if.master   gate,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic [IDX_W-1:0]     first_fail
);

    // Configuration guard, evaluated at elaboration.
    if (NVEC < 1 || NVEC > 4 || SETTLE < 1 || SETTLE > 15) begin : g_cfg_err
        $error("gate_vec_checker: NVEC must be 1..4 and SETTLE 1..15");
    end

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NVEC - 1);
    localparam logic [WAIT_W-1:0] SETTLE_LD = WAIT_W'(SETTLE);

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                fail_seen;
    logic                a_q;
    logic                b_q;
    logic [RESP_W-1:0]   y_exp_c;
    logic [RESP_W-1:0]   y_obs_c;
    logic                mismatch_c;

    assign gate.a = a_q;
    assign gate.b = b_q;

    // Expected response comes from the registered stimulus, not from idx.
    gate_ref_model u_ref (
        .a       (a_q),
        .b       (b_q),
        .y_exp_c (y_exp_c)
    );

    assign y_obs_c    = {gate.y1, gate.y2, gate.y3};
    assign mismatch_c = (y_obs_c != y_exp_c);

    // Checker FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            wait_cnt   <= '0;
            fail_seen  <= 1'b0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // busy is still high on the first DONE cycle: publish
                    // results there so err_count has settled; start is
                    // ignored until busy has dropped.
                    if (busy) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_count == '0);
                    end else if (start) begin
                        err_count  <= '0;
                        first_fail <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail_seen  <= 1'b0;
                        idx        <= '0;
                        busy       <= 1'b1;
                        state      <= APPLY;
                    end
                end

                APPLY: begin
                    a_q      <= idx[1];
                    b_q      <= idx[0];
                    wait_cnt <= SETTLE_LD;
                    state    <= WAIT;
                end

                // Exactly SETTLE cycles spent here per vector.
                WAIT: begin
                    wait_cnt <= wait_cnt - WAIT_W'(1);
                    if (wait_cnt == WAIT_W'(1)) begin
                        state <= CHECK;
                    end
                end

                CHECK: begin
                    if (mismatch_c) begin
                        if (err_count != ERR_SAT) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                        if (!fail_seen) begin
                            first_fail <= idx;
                            fail_seen  <= 1'b1;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= APPLY;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
